cnn_mac_seq: RTL
================

// Module: cnn_mac_seq
// PURPOSE
//  Sequences a single shared signed 8b x 14b multiplier (22b product) through a dot product:
//   weights (8s) . activations (14s) over LEN taps, plus bias, then arithmetic shift and saturate.
//  Sits between the conv2 weight/feature BRAMs and the output writer; one result per ap_start.
//  Block-level ap_start/ap_done/ap_idle/ap_ready handshake, as in the rest of the cnn datapath.
// PARAMETERS
//  ADDR_W  10  BRAM address width; max LEN = 2**ADDR_W
//  LEN_W   11  width of len input (ADDR_W+1)
//  ACC_W   32  accumulator width (signed)
//  OUT_W   16  saturated result width (signed)
// PORTS
//  ap_clk      in   1       clock, all logic rising-edge
//  ap_rst      in   1       synchronous reset, active-high
//  ap_start    in   1       start request, sampled in IDLE or DONE
//  ap_done     out  1       1-cycle pulse: result valid
//  ap_idle     out  1       high only in IDLE
//  ap_ready    out  1       equals ap_done (inputs may change)
//  len         in   LEN_W   number of taps, latched at start
//  bias        in   ACC_W   signed initial accumulator value, latched at start
//  shift       in   5       arithmetic right shift before saturation, latched at start
//  w_address0  out  ADDR_W  weight BRAM address
//  w_ce0       out  1       weight BRAM enable
//  w_q0        in   8       signed weight, valid 1 cycle after ce
//  x_address0  out  ADDR_W  activation BRAM address
//  x_ce0       out  1       activation BRAM enable
//  x_q0        in   14      signed activation, valid 1 cycle after ce
//  result      out  OUT_W   signed saturated result, held until next ap_done
// BEHAVIOUR
//  Reset: state=IDLE; ap_done=ap_ready=0, ap_idle=1, ce=0, addresses=0, result=0, acc=0, prod_r=0.
//  FSM: IDLE -> RUN (ap_start, len>0) | OUT (ap_start, len==0); RUN -> DRAIN after tap len-1 issued;
//   DRAIN (exactly 2 cycles) -> OUT; OUT (1 cycle) -> DONE; DONE (1 cycle) -> RUN/OUT if ap_start
//   (same rule as IDLE), else IDLE. ap_start ignored in RUN/DRAIN/OUT.
//  On accepted start: len/bias/shift latched; acc <= bias; tap counter k <= 0.
//  RUN: w_address0=x_address0=k, w_ce0=x_ce0=1, k++ each cycle; ce low in every other state.
//  Pipeline: addr @t -> q @t+1 -> prod_r <= w_q0*x_q0 (22b signed) end of t+1 -> acc += sext(prod_r) end of t+2.
//   Valid bits travel with the pipe so only real taps accumulate; no bubbles in RUN.
//  OUT: result <= sat_OUT_W(acc >>> shift) (floor, sign-preserving); ap_done/ap_ready high in DONE only.
//  Latency: start sampled at cycle 0 -> ap_done at cycle len+4 (len>0); cycle 2 for len==0.
//  Back-to-back: start held in DONE gives next RUN the following cycle; throughput len+4 cycles/result.
//  Saturation: > 2**(OUT_W-1)-1 -> 32767; < -2**(OUT_W-1) -> -32768 (OUT_W=16).
//  Accumulator wraps mod 2**ACC_W (no internal overflow detection; ACC_W=32 covers max LEN).
//  len > 2**ADDR_W: clamp to 2**ADDR_W taps.
//  ap_rst mid-operation: abort immediately, reset values next cycle, no ap_done for aborted job.
// STRUCTURE
//  Package cnn_mac_pkg: state enum {IDLE,RUN,DRAIN,OUT,DONE}, W_W=8, X_W=14, P_W=22, sat function.
//  One sub-module: cnn_mac_seq_mul, combinational signed 8x14->22 multiply (maps to a DSP48);
//   all pipeline registers (prod_r, valid bits) live in cnn_mac_seq.
// TESTING
//  1 len=3, w={1,-2,3}, x={100,200,-300}, bias=0, shift=0 -> result=-1200, ap_done at cycle 7.
//  2 len=4, all w=-128, x=-8192, bias=0, shift=6 -> acc=4194304, result=32767 (sat); shift=8 -> 16384.
//  3 len=0, bias=-5, shift=0 -> no ce pulses, result=-5, ap_done at cycle 2.
//  4 acc=-3 (len=1,w=-1,x=3,bias=0), shift=1 -> result=-2 (floor shift).
//  5 ap_start held high, two jobs len=2 -> ap_done at cycles 6 and 12, ce never high in DRAIN/OUT/DONE.
//  6 ap_rst at cycle 3 of len=8 job -> ap_idle=1, ce=0 next cycle, no ap_done; new job len=1 correct.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared types and helpers for the conv2 MAC sequencer.
// Holds the FSM state encoding, operand widths and the result saturation function.
package cnn_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT,
    DONE
  } state_t;

  localparam int unsigned W_W = 8;
  localparam int unsigned X_W = 14;
  localparam int unsigned P_W = 22;

  // Clamp a sign-extended value into the signed range of an ow-bit result.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/cnn_mac_seq_mul.sv
// Combinational signed 8b x 14b -> 22b multiply; the product register lives in the parent.
module cnn_mac_seq_mul
  import cnn_mac_pkg::*;
(
  input  logic signed [W_W-1:0] a,
  input  logic signed [X_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  logic signed [P_W-1:0] ae;
  logic signed [P_W-1:0] be;

  assign ae = $signed({{(P_W - W_W){a[W_W-1]}}, a});
  assign be = $signed({{(P_W - X_W){b[X_W-1]}}, b});
  assign p  = ae * be;

endmodule

// File: rtl/cnn_mac_seq.sv
// Dot-product sequencer: streams LEN weight/activation pairs through one shared
// multiplier, accumulates onto a bias, then shifts and saturates the result.
module cnn_mac_seq
  import cnn_mac_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [LEN_W-1:0]  len,
  input  logic [ACC_W-1:0]  bias,
  input  logic [4:0]        shift,
  output logic [ADDR_W-1:0] w_address0,
  output logic              w_ce0,
  input  logic [W_W-1:0]    w_q0,
  output logic [ADDR_W-1:0] x_address0,
  output logic              x_ce0,
  input  logic [X_W-1:0]    x_q0,
  output logic [OUT_W-1:0]  result
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t                    state;
  logic [LEN_W-1:0]          len_r;
  logic [LEN_W-1:0]          k;
  logic [4:0]                shift_r;
  logic signed [ACC_W-1:0]   acc;
  logic signed [P_W-1:0]     prod_r;
  logic signed [P_W-1:0]     prod_w;
  logic                      ce_r;
  logic                      vq;
  logic                      vp;
  logic                      dcnt;
  logic [LEN_W-1:0]          len_c;
  logic signed [ACC_W-1:0]   acc_sh;

  cnn_mac_seq_mul u_mul (
    .a (w_q0),
    .b (x_q0),
    .p (prod_w)
  );

  assign len_c      = (len > MAX_LEN) ? MAX_LEN : len;
  assign acc_sh     = acc >>> shift_r;
  assign w_address0 = k[ADDR_W-1:0];
  assign x_address0 = k[ADDR_W-1:0];
  assign w_ce0      = ce_r;
  assign x_ce0      = ce_r;
  assign ap_ready   = ap_done;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      ap_done <= 1'b0;
      ap_idle <= 1'b1;
      ce_r    <= 1'b0;
      k       <= '0;
      len_r   <= '0;
      shift_r <= '0;
      acc     <= '0;
      prod_r  <= '0;
      vq      <= 1'b0;
      vp      <= 1'b0;
      dcnt    <= 1'b0;
      result  <= '0;
    end else begin
      // Valid bits follow each issued tap: BRAM read, then product, then accumulate.
      vq     <= ce_r;
      vp     <= vq;
      prod_r <= prod_w;
      if (vp) acc <= acc + ACC_W'(prod_r);

      ap_done <= 1'b0;
      ap_idle <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (ap_start) begin
            len_r   <= len_c;
            shift_r <= shift;
            acc     <= $signed(bias);
            k       <= '0;
            if (len_c != '0) begin
              state <= RUN;
              ce_r  <= 1'b1;
            end else begin
              state <= OUT;
            end
          end else begin
            state   <= IDLE;
            ap_idle <= 1'b1;
          end
        end
        RUN: begin
          k <= k + LEN_W'(1);
          if (k == len_r - LEN_W'(1)) begin
            state <= DRAIN;
            ce_r  <= 1'b0;
            dcnt  <= 1'b0;
          end
        end
        DRAIN: begin
          dcnt <= 1'b1;
          if (dcnt) state <= OUT;
        end
        OUT: begin
          result  <= OUT_W'(sat({{(64 - ACC_W){acc_sh[ACC_W-1]}}, acc_sh}, OUT_W));
          state   <= DONE;
          ap_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
